// File: rtl/cpu_b_io_pkg.sv
// Shared definitions for the CPU_B I/O port controller.
//   OPCODE_IO           : instruction value that triggers an I/O transfer
//   DIR_IN / DIR_OUT    : io_input_output encodings
//   SEL_DATA / SEL_ADDR : io_data_address encodings
//   io_state_e          : controller FSM states
package cpu_b_io_pkg;

  localparam logic [3:0] OPCODE_IO = 4'h7;

  localparam logic DIR_IN   = 1'b0;
  localparam logic DIR_OUT  = 1'b1;

  localparam logic SEL_DATA = 1'b0;
  localparam logic SEL_ADDR = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OUT_WAIT = 2'd1,
    IN_WAIT  = 2'd2,
    DONE     = 2'd3
  } io_state_e;

endpackage

// File: rtl/io_timeout_ctr.sv
// Wait-cycle counter for one I/O transfer.
//   clk, reset : clock, synchronous active-high reset
//   clr        : restart the count (transfer accepted)
//   en         : controller is in a wait state this cycle
//   expired    : this wait cycle is the TIMEOUT-th one; the transfer
//                aborts at the coming edge unless the handshake lands.
//                Never asserted when TIMEOUT is 0.
module io_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT > 0) && en && (cnt_q == LAST);

endmodule

// File: rtl/io_port_ctrl.sv
// I/O port controller for CPU_B: runs one IO-instruction transfer at a time
// between the CPU and one of N_PORTS external modules.
//   start/instruction        : request from the Control Unit (opcode 4'h7)
//   io_input_output          : 0 = input, 1 = output
//   io_data_address          : 0 = data, 1 = address qualifier
//   port_sel, cpu_out        : target port and outgoing word
//   cpu_in                   : word captured from the port (0 on input timeout)
//   busy, done, err          : status; done is a one-cycle pulse
//   ext_out_*                : output handshake (one-hot valid, per-port ready)
//   ext_in_*                 : input handshake (one-hot req, per-port valid/data)
// Every output is a flop; its next value is derived from the next state.
module io_port_ctrl
  import cpu_b_io_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int N_PORTS = 4,
  parameter int PSEL_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [0:3]                 instruction,
  input  logic                       io_input_output,
  input  logic                       io_data_address,
  input  logic [PSEL_W-1:0]          port_sel,
  input  logic [DATA_W-1:0]          cpu_out,
  output logic [DATA_W-1:0]          cpu_in,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [DATA_W-1:0]          ext_out_data,
  output logic                       ext_data_address,
  output logic [N_PORTS-1:0]         ext_out_valid,
  input  logic [N_PORTS-1:0]         ext_out_ready,
  output logic [N_PORTS-1:0]         ext_in_req,
  input  logic [N_PORTS-1:0]         ext_in_valid,
  input  logic [N_PORTS*DATA_W-1:0]  ext_in_data
);

  function automatic logic [N_PORTS-1:0] decode_port(input logic [PSEL_W-1:0] sel);
    decode_port = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      decode_port[p] = (32'(sel) == p);
    end
  endfunction

  io_state_e           state_q, state_d;
  logic [PSEL_W-1:0]   port_q, port_d;
  logic [DATA_W-1:0]   cpu_in_q, cpu_in_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                da_q, da_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [N_PORTS-1:0]  out_valid_q, out_valid_d;
  logic [N_PORTS-1:0]  in_req_q, in_req_d;

  logic [N_PORTS-1:0]  sel_oh;
  logic                sel_ready;
  logic                sel_valid;
  logic [DATA_W-1:0]   in_slice;
  logic                accept;
  logic                port_ok;
  logic                ctr_clr;
  logic                ctr_en;
  logic                tmo_expired;

  assign sel_oh    = decode_port(port_q);
  assign sel_ready = |(ext_out_ready & sel_oh);
  assign sel_valid = |(ext_in_valid & sel_oh);
  assign accept    = start && (instruction == OPCODE_IO);
  assign port_ok   = int'(port_sel) < N_PORTS;

  always_comb begin
    in_slice = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      if (sel_oh[p]) begin
        in_slice = ext_in_data[p*DATA_W +: DATA_W];
      end
    end
  end

  io_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    cpu_in_d   = cpu_in_q;
    out_data_d = out_data_q;
    da_d       = da_q;
    err_d      = err_q;
    ctr_clr    = 1'b0;
    ctr_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ctr_clr = 1'b1;
          if (!port_ok) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d      = 1'b0;
            port_d     = port_sel;
            out_data_d = cpu_out;
            da_d       = io_data_address;
            state_d    = (io_input_output == DIR_OUT) ? OUT_WAIT : IN_WAIT;
          end
        end
      end
      // Handshake is tested before expiry so a same-edge arrival completes cleanly.
      OUT_WAIT: begin
        ctr_en = 1'b1;
        if (sel_ready) begin
          state_d = DONE;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      IN_WAIT: begin
        ctr_en = 1'b1;
        if (sel_valid) begin
          cpu_in_d = in_slice;
          state_d  = DONE;
        end else if (tmo_expired) begin
          cpu_in_d = '0;
          err_d    = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    out_valid_d = (state_d == OUT_WAIT) ? decode_port(port_d) : '0;
    in_req_d    = (state_d == IN_WAIT)  ? decode_port(port_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      port_q      <= '0;
      cpu_in_q    <= '0;
      out_data_q  <= '0;
      da_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= '0;
      in_req_q    <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      cpu_in_q    <= cpu_in_d;
      out_data_q  <= out_data_d;
      da_q        <= da_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_req_q    <= in_req_d;
    end
  end

  assign cpu_in           = cpu_in_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign ext_out_data     = out_data_q;
  assign ext_data_address = da_q;
  assign ext_out_valid    = out_valid_q;
  assign ext_in_req       = in_req_q;

endmodule
